// File: rtl/usr_pkg.sv
// usr_pkg: shared op encodings and FSM state type for the universal shift register
package usr_pkg;
  typedef enum logic [1:0] {OP_HOLD = 2'b00, OP_SHR = 2'b01, OP_SHL = 2'b10, OP_LOAD = 2'b11} op_e;
  typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, DONE = 2'b10} state_e;
endpackage

// File: rtl/usr_fsm_ctrl_param_if.sv
// usr_fsm_ctrl_param_if: command/status bundle of the USR controller
// master drives exe/slide/count/rotate/ser_in/d_in; slave returns q_out/busy/done
interface usr_fsm_ctrl_param_if #(parameter int WIDTH = 4, parameter int CNT_W = 3);
  logic             exe;
  logic [1:0]       slide;
  logic [CNT_W-1:0] count;
  logic             rotate;
  logic             ser_in;
  logic [WIDTH-1:0] d_in;
  logic [WIDTH-1:0] q_out;
  logic             busy;
  logic             done;
  modport master (output exe, slide, count, rotate, ser_in, d_in, input q_out, busy, done);
  modport slave  (input exe, slide, count, rotate, ser_in, d_in, output q_out, busy, done);
endinterface

// File: rtl/usr_datapath.sv
// usr_datapath: WIDTH-bit shift/load register advanced one step per enabled clock
// ports: clk, reset (async low), step enable, op, rot, ser_in, ld -> q
module usr_datapath
  import usr_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             step,
  input  op_e              op,
  input  logic             rot,
  input  logic             ser_in,
  input  logic [WIDTH-1:0] ld,
  output logic [WIDTH-1:0] q
);
  logic [WIDTH-1:0] q_q, q_d;
  logic             s_r, s_l;
  always_comb begin
    s_r = rot ? q_q[0] : ser_in;
    s_l = rot ? q_q[WIDTH-1] : ser_in;
    q_d = !step           ? q_q :
          (op == OP_SHR)  ? {s_r, q_q[WIDTH-1:1]} :
          (op == OP_SHL)  ? {q_q[WIDTH-2:0], s_l} :
          (op == OP_LOAD) ? ld : q_q;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) q_q <= '0;
    else        q_q <= q_d;
  assign q = q_q;
endmodule

// File: rtl/usr_fsm_ctrl_param.sv
// usr_fsm_ctrl_param: exe-edge triggered controller running hold/shift/load on a USR
// ports: clk, reset (async low), bus (slave: exe/slide/count/rotate/ser_in/d_in in, q_out/busy/done out)
module usr_fsm_ctrl_param
  import usr_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
) (
  input logic                  clk,
  input logic                  reset,
  usr_fsm_ctrl_param_if.slave  bus
);
  state_e           state_q, state_d;
  op_e              op_q, op_d;
  logic             rot_q, rot_d;
  logic [WIDTH-1:0] ld_q, ld_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             exe_q;
  logic             rise, step, shift_op, last;
  assign rise = bus.exe & ~exe_q;
  assign shift_op = (op_q == OP_SHR) || (op_q == OP_SHL);
  // exit is decided on the current count, so cnt reaches 0 at most and never wraps
  assign last = !shift_op || (cnt_q == CNT_W'(1));
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    rot_d   = rot_q;
    ld_d    = ld_q;
    cnt_d   = cnt_q;
    step    = 1'b0;
    case (state_q)
      IDLE: if (rise) begin
        op_d    = op_e'(bus.slide);
        rot_d   = bus.rotate;
        ld_d    = bus.d_in;
        cnt_d   = bus.count;
        state_d = ((bus.slide == OP_SHR || bus.slide == OP_SHL) && bus.count == '0) ? DONE : RUN;
      end
      RUN: begin
        step    = 1'b1;
        cnt_d   = shift_op ? cnt_q - CNT_W'(1) : cnt_q;
        state_d = last ? DONE : RUN;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state_q <= IDLE;
      op_q    <= OP_HOLD;
      rot_q   <= 1'b0;
      ld_q    <= '0;
      cnt_q   <= '0;
      exe_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      rot_q   <= rot_d;
      ld_q    <= ld_d;
      cnt_q   <= cnt_d;
      exe_q   <= bus.exe;
    end
  usr_datapath #(.WIDTH(WIDTH)) u_dp (
    .clk    (clk),
    .reset  (reset),
    .step   (step),
    .op     (op_q),
    .rot    (rot_q),
    .ser_in (bus.ser_in),
    .ld     (ld_q),
    .q      (bus.q_out)
  );
  assign bus.busy = (state_q == RUN);
  assign bus.done = (state_q == DONE);
endmodule

// File: tb/tb_usr_fsm_ctrl_param.sv
// tb_usr_fsm_ctrl_param: directed and randomized command checks against a transaction-level model
module tb_usr_fsm_ctrl_param;
  localparam int W = 4;
  localparam int MASK = (1 << W) - 1;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int checks = 0;
  int failures = 0;
  int mq = 0;
  usr_fsm_ctrl_param_if #(.WIDTH(W), .CNT_W(3)) bus ();
  usr_fsm_ctrl_param #(.WIDTH(W), .CNT_W(3)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic cmd(input int op, input int n, input int rot, input int din, input int fill);
    int steps, sv, s;
    bit zero;
    zero  = (op == 1 || op == 2) && n == 0;
    steps = (op == 1 || op == 2) ? n : 1;
    @(negedge clk);
    bus.slide = 2'(op); bus.count = 3'(n); bus.rotate = rot[0]; bus.d_in = 4'(din); bus.exe = 1'b1;
    @(posedge clk); #1;
    check("t0_busy", int'(bus.busy), zero ? 0 : 1);
    check("t0_done", int'(bus.done), zero ? 1 : 0);
    check("t0_q", int'(bus.q_out), mq);
    bus.slide = 2'($urandom); bus.count = 3'($urandom); bus.rotate = 1'($urandom); bus.d_in = 4'($urandom);
    if (!zero) for (int k = 1; k <= steps; k++) begin
      sv = (fill < 0) ? int'($urandom_range(0, 1)) : fill;
      bus.ser_in = sv[0];
      bus.exe = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      if (op == 1) begin
        s  = rot != 0 ? (mq & 1) : sv;
        mq = (mq >> 1) | (s << (W - 1));
      end else if (op == 2) begin
        s  = rot != 0 ? ((mq >> (W - 1)) & 1) : sv;
        mq = ((mq << 1) | s) & MASK;
      end else if (op == 3) mq = din & MASK;
      check("step_q", int'(bus.q_out), mq);
      check("step_busy", int'(bus.busy), k < steps ? 1 : 0);
      check("step_done", int'(bus.done), k == steps ? 1 : 0);
    end
    bus.exe = 1'b0;
    @(posedge clk); #1;
    check("end_done", int'(bus.done), 0);
    check("end_busy", int'(bus.busy), 0);
    check("end_q", int'(bus.q_out), mq);
  endtask
  initial begin
    int dones;
    bus.exe = 1'b0; bus.slide = 2'b00; bus.count = 3'd0; bus.rotate = 1'b0; bus.ser_in = 1'b0; bus.d_in = 4'd0;
    #1;
    check("rst_q", int'(bus.q_out), 0);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_done", int'(bus.done), 0);
    @(negedge clk); reset = 1'b1;
    cmd(3, 0, 0, 4'b1011, 0);
    #2 reset = 1'b0;
    #1;
    check("async_rst_q", int'(bus.q_out), 0);
    check("async_rst_busy", int'(bus.busy), 0);
    check("async_rst_done", int'(bus.done), 0);
    mq = 0;
    @(negedge clk); reset = 1'b1;
    cmd(3, 5, 1, 4'b1011, 0);
    check("load_val", int'(bus.q_out), 4'b1011);
    cmd(1, 2, 1, 0, 0);
    check("rotr_val", int'(bus.q_out), 4'b1110);
    cmd(3, 0, 0, 4'b1011, 0);
    cmd(2, 3, 0, 0, 0);
    check("shl_fill_val", int'(bus.q_out), 4'b1000);
    cmd(3, 0, 0, 4'b0110, 0);
    dones = 0;
    @(negedge clk);
    bus.slide = 2'b01; bus.count = 3'd1; bus.rotate = 1'b1; bus.exe = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      dones += int'(bus.done);
    end
    bus.exe = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      dones += int'(bus.done);
    end
    mq = ((mq >> 1) | ((mq & 1) << (W - 1)));
    check("held_dones", dones, 1);
    check("held_q", int'(bus.q_out), mq);
    cmd(1, 0, 0, 0, -1);
    cmd(2, 0, 1, 0, -1);
    cmd(3, 0, 0, 4'b1001, 0);
    @(negedge clk);
    bus.slide = 2'b01; bus.count = 3'd7; bus.rotate = 1'b1; bus.exe = 1'b1;
    @(posedge clk);
    repeat (3) @(posedge clk);
    #3 reset = 1'b0;
    #1;
    check("midrun_rst_q", int'(bus.q_out), 0);
    check("midrun_rst_busy", int'(bus.busy), 0);
    check("midrun_rst_done", int'(bus.done), 0);
    bus.exe = 1'b0;
    mq = 0;
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    check("post_rst_busy", int'(bus.busy), 0);
    cmd(3, 0, 0, 4'b0101, 0);
    for (int i = 0; i < 150; i++)
      cmd(int'($urandom_range(0, 3)), int'($urandom_range(0, 7)), int'($urandom_range(0, 1)), int'($urandom_range(0, MASK)), -1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
